operand_fetch: RTL and testbench

- Issue/operand-fetch stage directly upstream of the 16x16 register file.
- Accepts one 16-bit instruction per valid/ready handshake and decodes which sources it reads and whether it writes a destination.
- Stalls on read-after-write and write-after-write hazards using a 16-entry pending-write scoreboard, then drives the register file read ports and captures the operands.
- Presents the operand bundle to the execute stage with a valid/ready handshake; writeback notifications clear scoreboard entries.

---
 rtl/operand_fetch_pkg.sv | 56 +++++
 rtl/instr_class_decode.sv | 39 +++
 rtl/operand_fetch.sv | 155 +++++++++++++++
 tb/tb_operand_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared definitions for the operand-fetch stage: datapath sizes, opcode
//   values, instruction field positions, FSM state encoding, the decoded
//   instruction-class bundle and a register-id to one-hot helper.
package operand_fetch_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_N    = 16;
  localparam int REG_ID_W = $clog2(REG_N);
  localparam int INSTR_W  = 16;

  // Opcodes; 0x1..0x9 are all register-register ALU operations.
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h9;
  localparam logic [3:0] OP_LDI    = 4'hA;
  localparam logic [3:0] OP_LD     = 4'hB;
  localparam logic [3:0] OP_ST     = 4'hC;
  localparam logic [3:0] OP_BEQ    = 4'hD;
  localparam logic [3:0] OP_JMP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Instruction field positions. imm8 overlaps rs1/rs2.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    READ  = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic uses_imm;
  } instr_class_t;

  function automatic logic [REG_N-1:0] reg_onehot(input logic [REG_ID_W-1:0] id);
    logic [REG_N-1:0] mask;
    mask = '0;
    mask[id] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode
//   Combinational opcode classifier: which source registers an instruction
//   reads, whether it writes rd, and whether operand B comes from imm8.
// Ports:
//   opcode - instruction opcode field
//   cls    - {uses_rs1, uses_rs2, writes_rd, uses_imm}
module instr_class_decode
  import operand_fetch_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
      cls.uses_rs1  = 1'b1;
      cls.uses_rs2  = 1'b1;
      cls.writes_rd = 1'b1;
    end else begin
      case (opcode)
        OP_LDI: begin
          cls.writes_rd = 1'b1;
          cls.uses_imm  = 1'b1;
        end
        OP_LD: begin
          cls.uses_rs1  = 1'b1;
          cls.writes_rd = 1'b1;
        end
        OP_ST, OP_BEQ: begin
          cls.uses_rs1 = 1'b1;
          cls.uses_rs2 = 1'b1;
        end
        default: cls = '0; // NOP, JMP, HALT touch no registers
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Issue / operand-fetch stage in front of the 16x16 register file.
//   Accepts one instruction per handshake, stalls on RAW/WAW hazards using a
//   pending-write scoreboard, reads the register file for one cycle and then
//   presents the operand bundle to execute.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_instr        - instruction input handshake
//   flush                             - kill in-flight instruction
//   wb_valid/wb_reg                   - writeback completion, clears scoreboard
//   rf_rd1/2, rf_wn1/2, rf_id1/2      - register file port control
//   rf_data1/2                        - register file read data
//   out_valid/out_ready               - operand bundle handshake
//   out_opcode/out_dest/out_op_a/b    - operand bundle
//   busy_mask                         - scoreboard contents
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_ID_W-1:0] wb_reg,
  output logic                rf_rd1,
  output logic                rf_rd2,
  output logic                rf_wn1,
  output logic                rf_wn2,
  output logic [REG_ID_W-1:0] rf_id1,
  output logic [REG_ID_W-1:0] rf_id2,
  input  logic [DATA_W-1:0]   rf_data1,
  input  logic [DATA_W-1:0]   rf_data2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_opcode,
  output logic [REG_ID_W-1:0] out_dest,
  output logic [DATA_W-1:0]   out_op_a,
  output logic [DATA_W-1:0]   out_op_b,
  output logic [REG_N-1:0]    busy_mask
);

  state_t             state, state_next;
  logic [INSTR_W-1:0] instr_q;
  logic [REG_N-1:0]   scoreboard;

  // In IDLE the hazard decision is made on the incoming instruction so that
  // an accept can go straight to READ; afterwards the latched copy is used.
  logic [INSTR_W-1:0]  cur_instr;
  logic [3:0]          cur_opcode;
  logic [REG_ID_W-1:0] cur_rd, cur_rs1, cur_rs2;
  logic [7:0]          cur_imm;
  instr_class_t        cls;

  assign cur_instr  = (state == IDLE) ? in_instr : instr_q;
  assign cur_opcode = cur_instr[OPC_MSB:OPC_LSB];
  assign cur_rd     = cur_instr[RD_MSB:RD_LSB];
  assign cur_rs1    = cur_instr[RS1_MSB:RS1_LSB];
  assign cur_rs2    = cur_instr[RS2_MSB:RS2_LSB];
  assign cur_imm    = cur_instr[IMM_MSB:IMM_LSB];

  instr_class_decode u_decode (
    .opcode (cur_opcode),
    .cls    (cls)
  );

  // A writeback landing this cycle already counts as resolved, so the
  // dependent instruction leaves STALL without an extra bubble.
  logic [REG_N-1:0] need, wb_clear, sb_set;
  logic             hazard;

  assign need = (cls.uses_rs1  ? reg_onehot(cur_rs1) : '0)
              | (cls.uses_rs2  ? reg_onehot(cur_rs2) : '0)
              | (cls.writes_rd ? reg_onehot(cur_rd)  : '0);
  assign wb_clear = wb_valid ? reg_onehot(wb_reg) : '0;
  assign hazard   = |(need & scoreboard & ~wb_clear);
  assign sb_set   = (state == READ && !flush && cls.writes_rd) ? reg_onehot(cur_rd) : '0;

  assign rf_wn1    = 1'b0;
  assign rf_wn2    = 1'b0;
  assign busy_mask = scoreboard;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rf_rd1     = 1'b0;
    rf_rd2     = 1'b0;
    rf_id1     = '0;
    rf_id2     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = hazard ? STALL : READ;
      end
      STALL: begin
        if (!hazard) state_next = READ;
      end
      READ: begin
        rf_rd1     = cls.uses_rs1;
        rf_rd2     = cls.uses_rs2;
        rf_id1     = cls.uses_rs1 ? cur_rs1 : '0;
        rf_id2     = cls.uses_rs2 ? cur_rs2 : '0;
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid && !flush) instr_q <= in_instr;
    end
  end

  // Operand capture happens on the edge that ends READ; a flush wipes the
  // bundle so nothing stale is left on the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_opcode <= '0;
      out_dest   <= '0;
      out_op_a   <= '0;
      out_op_b   <= '0;
    end else if (flush) begin
      out_opcode <= '0;
      out_dest   <= '0;
      out_op_a   <= '0;
      out_op_b   <= '0;
    end else if (state == READ) begin
      out_opcode <= cur_opcode;
      out_dest   <= cur_rd;
      out_op_a   <= cls.uses_rs1 ? rf_data1 : '0;
      if (cls.uses_rs2)      out_op_b <= rf_data2;
      else if (cls.uses_imm) out_op_b <= {{(DATA_W-8){1'b0}}, cur_imm};
      else                   out_op_b <= '0;
    end
  end

  // Set is applied after clear so a same-cycle set/clear of one bit keeps it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scoreboard <= '0;
    else        scoreboard <= (scoreboard & ~wb_clear) | sb_set;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Self-checking bench for operand_fetch: directed corner sequences, a
//   table of one instruction per class, and randomized instructions checked
//   against a behavioural model (pending-register set plus register file
//   array kept in the bench).
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        rf_rd1, rf_rd2, rf_wn1, rf_wn2;
  logic [3:0]  rf_id1, rf_id2;
  logic [15:0] rf_data1, rf_data2;
  logic        out_valid, out_ready;
  logic [3:0]  out_opcode, out_dest;
  logic [15:0] out_op_a, out_op_b;
  logic [15:0] busy_mask;

  logic [15:0] rf [16];
  int          total_checks = 0;
  int          passed_checks = 0;

  assign rf_data1 = rf[rf_id1];
  assign rf_data2 = rf[rf_id2];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rf_wn1     (rf_wn1),
    .rf_wn2     (rf_wn2),
    .rf_id1     (rf_id1),
    .rf_id2     (rf_id2),
    .rf_data1   (rf_data1),
    .rf_data2   (rf_data2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .out_op_a   (out_op_a),
    .out_op_b   (out_op_b),
    .busy_mask  (busy_mask)
  );

  typedef struct {
    logic [15:0] instr;
    logic        rd1, rd2;
    logic [3:0]  id1, id2;
    logic [15:0] op_a, op_b;
    logic [15:0] busy;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed_checks++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in IDLE; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [15:0] instr);
    @(negedge clk);
    check_output("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_instr = instr;
    step();
    in_valid = 1'b0;
    in_instr = $urandom;
  endtask

  // Spec decode table.
  task automatic model_decode(input logic [3:0] op, output bit u1, output bit u2,
                              output bit w, output bit imm);
    u1 = 0; u2 = 0; w = 0; imm = 0;
    if (op >= 4'h1 && op <= 4'h9) begin u1 = 1; u2 = 1; w = 1; end
    else if (op == 4'hA) begin w = 1; imm = 1; end
    else if (op == 4'hB) begin u1 = 1; w = 1; end
    else if (op == 4'hC || op == 4'hD) begin u1 = 1; u2 = 1; end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t        vecs [9];
    bit          pend [16];
    logic [15:0] exp_busy;

    for (int i = 0; i < 16; i++) rf[i] = 16'(i + 5);
    for (int i = 0; i < 16; i++) pend[i] = 0;
    reset = 1'b0; in_valid = 0; in_instr = 0; flush = 0;
    wb_valid = 0; wb_reg = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy_mask, 0);
    check_output("rst_rf_rd", {rf_rd1, rf_rd2, rf_wn1, rf_wn2}, 0);
    check_output("rst_op", {out_op_a, out_op_b, out_opcode, out_dest}, 0);
    step();

    // Basic ADD r3 = r1 + r2
    apply_stimulus(16'h1312);
    @(negedge clk);
    check_output("add_rd", {rf_rd1, rf_rd2}, 2'b11);
    check_output("add_ids", {rf_id1, rf_id2}, 8'h12);
    check_output("add_nvalid", out_valid, 0);
    step();
    @(negedge clk);
    check_output("add_valid", out_valid, 1);
    check_output("add_rd_off", {rf_rd1, rf_rd2}, 0);
    check_output("add_a", out_op_a, 16'h0006);
    check_output("add_b", out_op_b, 16'h0007);
    check_output("add_busy", busy_mask, 16'h0008);
    check_output("add_meta", {out_opcode, out_dest}, 8'h13);
    step();

    // RAW stall on r3, resolved by a writeback
    apply_stimulus(16'h2434);
    @(negedge clk);
    check_output("raw_stall_ready", in_ready, 0);
    check_output("raw_stall_rd", rf_rd1, 0);
    check_output("raw_busy", busy_mask, 16'h0008);
    step();
    @(negedge clk);
    check_output("raw_still_stall", {out_valid, rf_rd1}, 0);
    step();
    wb_valid = 1; wb_reg = 3;
    @(negedge clk);
    check_output("raw_wb_cycle", rf_rd1, 0);
    step();
    wb_valid = 0;
    @(negedge clk);
    check_output("raw_read", {rf_rd1, rf_rd2, rf_id1, rf_id2}, {2'b11, 8'h34});
    step();
    @(negedge clk);
    check_output("raw_valid", out_valid, 1);
    check_output("raw_a", out_op_a, 16'h0008);
    check_output("raw_b", out_op_b, 16'h0009);
    check_output("raw_busy_after", busy_mask, 16'h0010);
    step();

    // Set and clear of r3 in the same cycle: set wins
    apply_stimulus(16'h1312);
    wb_valid = 1; wb_reg = 3;
    @(negedge clk);
    check_output("sc_read", rf_rd1, 1);
    step();
    wb_valid = 0;
    @(negedge clk);
    check_output("sc_busy", busy_mask, 16'h0018);
    step();
    wb_valid = 1; wb_reg = 3; step();
    wb_reg = 4; step();
    wb_reg = 9; step();
    wb_valid = 0;
    @(negedge clk);
    check_output("sc_cleared", busy_mask, 0);
    step();

    // LDI with backpressure
    out_ready = 0;
    apply_stimulus(16'hA5F0);
    @(negedge clk);
    check_output("ldi_no_read", {rf_rd1, rf_rd2}, 0);
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("bp_valid", out_valid, 1);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_bundle", {out_opcode, out_dest, out_op_a, out_op_b}, {8'hA5, 16'h0000, 16'h00F0});
      check_output("bp_busy", busy_mask, 16'h0020);
      step();
    end
    out_ready = 1;
    step();
    @(negedge clk);
    check_output("bp_idle", {in_ready, out_valid}, 2'b10);
    step();
    apply_stimulus(16'h0000);
    step();
    @(negedge clk);
    check_output("bp_next_valid", out_valid, 1);
    check_output("bp_next_opc", out_opcode, 0);
    step();

    // Flush during READ
    apply_stimulus(16'h1712);
    flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    check_output("fl_idle", {in_ready, out_valid, rf_rd1, rf_rd2}, 4'b1000);
    check_output("fl_bundle", {out_opcode, out_dest, out_op_a, out_op_b}, 0);
    check_output("fl_busy", busy_mask, 16'h0020);
    step();

    // Reset while stalled on r5
    apply_stimulus(16'h2650);
    @(negedge clk);
    check_output("rs_stall", in_ready, 0);
    #2 reset = 0;
    #1;
    check_output("rs_idle", {in_ready, out_valid, rf_rd1, rf_rd2}, 4'b1000);
    check_output("rs_busy", busy_mask, 0);
    check_output("rs_bundle", {out_opcode, out_dest, out_op_a, out_op_b}, 0);
    step();
    reset = 1;
    step();

    // One instruction per class with an empty scoreboard
    vecs[0] = '{16'h0123, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{16'h5A12, 1, 1, 4'h1, 4'h2, 16'h0006, 16'h0007, 16'h0400};
    vecs[2] = '{16'h9FE0, 1, 1, 4'hE, 4'h0, 16'h0013, 16'h0005, 16'h8000};
    vecs[3] = '{16'hA3FF, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h00FF, 16'h0008};
    vecs[4] = '{16'hB2C7, 1, 0, 4'hC, 4'h0, 16'h0011, 16'h0000, 16'h0004};
    vecs[5] = '{16'hC1AB, 1, 1, 4'hA, 4'hB, 16'h000F, 16'h0010, 16'h0000};
    vecs[6] = '{16'hD034, 1, 1, 4'h3, 4'h4, 16'h0008, 16'h0009, 16'h0000};
    vecs[7] = '{16'hE777, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{16'hF000, 0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    for (int v = 0; v < 9; v++) begin
      apply_stimulus(vecs[v].instr);
      @(negedge clk);
      check_output($sformatf("tbl%0d_read", v), {rf_rd1, rf_rd2, rf_id1, rf_id2},
                   {vecs[v].rd1, vecs[v].rd2, vecs[v].id1, vecs[v].id2});
      step();
      @(negedge clk);
      check_output($sformatf("tbl%0d_valid", v), out_valid, 1);
      check_output($sformatf("tbl%0d_ops", v), {out_op_a, out_op_b}, {vecs[v].op_a, vecs[v].op_b});
      check_output($sformatf("tbl%0d_meta", v), {out_opcode, out_dest}, vecs[v].instr[15:8]);
      check_output($sformatf("tbl%0d_busy", v), busy_mask, vecs[v].busy);
      step();
      wb_valid = 1; wb_reg = vecs[v].instr[11:8];
      step();
      wb_valid = 0;
    end

    // Randomized instructions against the pending-set model
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    for (int n = 0; n < 60; n++) begin
      logic [15:0] instr;
      logic [3:0]  op, rd, rs1, rs2;
      bit          u1, u2, w, imm, hz;
      int          k;
      logic [15:0] exp_b;

      if ($urandom_range(1, 0) == 1) begin
        int r;
        r = $urandom_range(15, 0);
        wb_valid = 1; wb_reg = 4'(r);
        step();
        wb_valid = 0;
        pend[r] = 0;
      end
      instr = 16'($urandom);
      op = instr[15:12]; rd = instr[11:8]; rs1 = instr[7:4]; rs2 = instr[3:0];
      model_decode(op, u1, u2, w, imm);
      hz = 0;
      for (int i = 0; i < 16; i++)
        if (pend[i] && ((u1 && rs1 == i) || (u2 && rs2 == i) || (w && rd == i))) hz = 1;
      k = $urandom_range(2, 0);
      out_ready = (k == 0);

      apply_stimulus(instr);
      if (hz) begin
        @(negedge clk);
        check_output("rnd_stall", {in_ready, rf_rd1, rf_rd2, out_valid}, 0);
        for (int i = 0; i < 16; i++)
          if (pend[i] && ((u1 && rs1 == i) || (u2 && rs2 == i) || (w && rd == i))) begin
            wb_valid = 1; wb_reg = 4'(i);
            step();
            pend[i] = 0;
          end
        wb_valid = 0;
      end
      @(negedge clk);
      check_output("rnd_read", {rf_rd1, rf_rd2, rf_id1, rf_id2},
                   {u1, u2, (u1 ? rs1 : 4'h0), (u2 ? rs2 : 4'h0)});
      step();
      if (w) pend[rd] = 1;
      exp_busy = '0;
      for (int i = 0; i < 16; i++) exp_busy[i] = pend[i];
      exp_b = u2 ? rf[rs2] : (imm ? {8'h00, instr[7:0]} : 16'h0000);
      for (int c = 0; c <= k; c++) begin
        @(negedge clk);
        check_output("rnd_valid", out_valid, 1);
        check_output("rnd_a", out_op_a, u1 ? rf[rs1] : 16'h0000);
        check_output("rnd_b", out_op_b, exp_b);
        check_output("rnd_meta", {out_opcode, out_dest}, {op, rd});
        check_output("rnd_busy", busy_mask, exp_busy);
        if (c < k) step();
      end
      out_ready = 1;
      step();
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
